// File: rtl/fp_to_fixed_conv_if.sv
// fp_to_fixed_conv_if: beg/ready/ack handshake and data bus for the float-to-fixed converter
interface fp_to_fixed_conv_if #(parameter int W = 32, parameter int FW = 32);
   logic          beg_i;
   logic          ack_i;
   logic [W-1:0]  float_i;
   logic [FW-1:0] fixed_o;
   logic          ovf_o;
   logic          unf_o;
   logic          busy_o;
   logic          ready_o;
   modport master (output beg_i, ack_i, float_i, input fixed_o, ovf_o, unf_o, busy_o, ready_o);
   modport slave  (input beg_i, ack_i, float_i, output fixed_o, ovf_o, unf_o, busy_o, ready_o);
endinterface

// File: rtl/fp_to_fixed_conv.sv
// fp_to_fixed_conv: multi-cycle float to signed fixed-point converter with rounding and saturation
module fp_to_fixed_conv #(
   parameter int W       = 32,
   parameter int EW      = 8,
   parameter int SW      = 23,
   parameter int BIAS    = 127,
   parameter int FW      = 32,
   parameter int SW_FRAC = 16
) (
   input logic clk,
   input logic rst,
   fp_to_fixed_conv_if.slave bus
);
   localparam int IB = FW - SW_FRAC - 1;
   typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, SIGN, DONE} state_t;
   state_t          r_state;
   logic [W-1:0]    r_float;
   logic [FW:0]     r_mag;
   logic [EW+1:0]   r_cnt;
   logic            r_right;
   logic            r_guard;
   logic [FW-1:0]   r_fixed;
   logic            r_ovf;
   logic            r_unf;
   logic            r_busy;
   logic            r_ready;
   logic            w_sign;
   logic [EW-1:0]   w_exp;
   logic [SW-1:0]   w_frac;
   logic signed [EW+1:0] w_e;
   logic signed [EW+1:0] w_sh;
   logic [EW+1:0]   w_abs;
   logic            w_big;
   logic            w_tiny;
   logic [FW:0]     w_lim;
   logic [FW-1:0]   w_sat;
   logic [FW-1:0]   w_res;
   assign w_sign = r_float[W-1];
   assign w_exp  = r_float[W-2:SW];
   assign w_frac = r_float[SW-1:0];
   assign w_e    = $signed({2'b00, w_exp}) - $signed((EW+2)'(BIAS));
   assign w_sh   = w_e - $signed((EW+2)'(SW - SW_FRAC));
   assign w_abs  = w_sh[EW+1] ? (EW+2)'(-w_sh) : (EW+2)'(w_sh);
   assign w_big  = w_e >= $signed((EW+2)'(IB));
   assign w_tiny = w_e < -$signed((EW+2)'(SW_FRAC + 1));
   assign w_lim  = w_sign ? (FW+1)'(1) << (FW-1) : ((FW+1)'(1) << (FW-1)) - (FW+1)'(1);
   assign w_sat  = w_sign ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
   assign w_res  = w_sign ? FW'(-r_mag) : r_mag[FW-1:0];
   // Special cases route through SIGN with a forced magnitude: all-ones saturates, zero flushes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_float <= '0;
         r_mag   <= '0;
         r_cnt   <= '0;
         r_right <= 1'b0;
         r_guard <= 1'b0;
         r_fixed <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.beg_i) begin
               r_float <= bus.float_i;
               r_ovf   <= 1'b0;
               r_unf   <= 1'b0;
               r_busy  <= 1'b1;
               r_state <= DECODE;
            end
            DECODE: begin
               r_guard <= 1'b0;
               r_right <= w_sh[EW+1];
               r_cnt   <= w_abs;
               if (w_exp == '1 || w_big) begin
                  r_mag   <= '1;
                  r_state <= SIGN;
               end else if (w_exp == '0 || w_tiny) begin
                  r_mag   <= '0;
                  r_unf   <= (w_exp != '0) || (w_frac != '0);
                  r_state <= SIGN;
               end else begin
                  r_mag   <= (FW+1)'({1'b1, w_frac});
                  r_state <= (w_abs != '0) ? SHIFT : ROUND;
               end
            end
            SHIFT: begin
               if (r_right) begin
                  r_guard <= r_mag[0];
                  r_mag   <= r_mag >> 1;
               end else begin
                  r_mag <= r_mag << 1;
               end
               r_cnt <= r_cnt - (EW+2)'(1);
               if (r_cnt == (EW+2)'(1)) r_state <= ROUND;
            end
            ROUND: begin
               r_mag   <= r_mag + (FW+1)'(r_guard);
               r_state <= SIGN;
            end
            SIGN: begin
               r_ovf   <= r_mag > w_lim;
               r_fixed <= (r_mag > w_lim) ? w_sat : w_res;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= DONE;
            end
            DONE: if (bus.ack_i) begin
               r_ready <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.fixed_o = r_fixed;
   assign bus.ovf_o   = r_ovf;
   assign bus.unf_o   = r_unf;
   assign bus.busy_o  = r_busy;
   assign bus.ready_o = r_ready;
endmodule

// File: tb/tb_fp_to_fixed_conv.sv
// tb_fp_to_fixed_conv: random and directed float inputs checked against an arithmetic Q15.16 model
module tb_fp_to_fixed_conv;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_err = 0;
   fp_to_fixed_conv_if #(.W(32), .FW(32)) bus ();
   fp_to_fixed_conv dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Value-level reference: round-half-up of |x|*2^16 on the magnitude, then sign and clamp
   function automatic void model(input logic [31:0] f, output logic [31:0] fx,
                                 output logic ov, output logic un, output int lat);
      int e, sh;
      longint m, mag, lim;
      logic [31:0] sat;
      sat = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      lim = f[31] ? 64'h8000_0000 : 64'h7FFF_FFFF;
      ov = 1'b0; un = 1'b0; fx = '0; lat = 2;
      e = int'(f[30:23]) - 127;
      if (f[30:23] == 8'hFF || (f[30:23] != 8'h00 && e >= 15)) begin
         ov = 1'b1; fx = sat;
      end else if (f[30:23] == 8'h00) begin
         un = (f[22:0] != '0);
      end else if (e < -17) begin
         un = 1'b1;
      end else begin
         m = longint'({1'b1, f[22:0]});
         sh = e - 7;
         lat = 3 + (sh < 0 ? -sh : sh);
         mag = (sh >= 0) ? (m << sh) : ((m + (longint'(1) << (-sh - 1))) >> (-sh));
         if (mag > lim) begin
            ov = 1'b1; fx = sat;
         end else begin
            fx = f[31] ? 32'(-mag) : 32'(mag);
         end
      end
   endfunction

   task automatic convert(input logic [31:0] f);
      logic [31:0] ef;
      logic eo, eu;
      int el, n;
      model(f, ef, eo, eu, el);
      @(negedge clk);
      bus.float_i = f;
      bus.beg_i = 1'b1;
      @(posedge clk);
      #1;
      bus.beg_i = 1'b0;
      bus.float_i = $urandom;
      chk("busy", 64'(bus.busy_o), 64'd1);
      n = 0;
      while (!bus.ready_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("lat %h", f), 64'(n), 64'(el));
      chk($sformatf("fixed %h", f), 64'(bus.fixed_o), 64'(ef));
      chk($sformatf("ovf %h", f), 64'(bus.ovf_o), 64'(eo));
      chk($sformatf("unf %h", f), 64'(bus.unf_o), 64'(eu));
      @(negedge clk);
      bus.ack_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ack_i = 1'b0;
      chk("ready_after_ack", 64'(bus.ready_o), 64'd0);
   endtask

   logic [31:0] dir [12] = '{32'h3F80_0000, 32'hC020_0000, 32'h3700_0000, 32'h3680_0000,
                             32'h471C_4000, 32'hC71C_4000, 32'h7FC0_0000, 32'h0000_0000,
                             32'h8000_0000, 32'h0000_0001, 32'h46FF_FE00, 32'hC700_0000};

   initial begin
      logic [31:0] f, held;
      bus.beg_i = 1'b0;
      bus.ack_i = 1'b0;
      bus.float_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_fixed", 64'(bus.fixed_o), 64'd0);
      chk("rst_flags", 64'({bus.ovf_o, bus.unf_o, bus.busy_o, bus.ready_o}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      foreach (dir[i]) convert(dir[i]);
      for (int i = 0; i < 60; i++) begin
         f = $urandom;
         if (i % 4 != 0) f[30:23] = 8'($urandom_range(105, 145));
         convert(f);
      end
      // outputs hold through the next conversion until its DONE
      convert(32'h3F80_0000);
      @(negedge clk);
      bus.float_i = 32'hC020_0000;
      bus.beg_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("hold_fixed", 64'(bus.fixed_o), 64'h0001_0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_fixed", 64'(bus.fixed_o), 64'd0);
      chk("abort_flags", 64'({bus.ovf_o, bus.unf_o, bus.busy_o, bus.ready_o}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.beg_i = 1'b0;
      convert(32'h4700_0000);
      @(negedge clk);
      bus.float_i = 32'hC020_0000;
      bus.beg_i = 1'b1;
      for (int i = 0; i < 100 && !bus.ready_o; i++) begin
         @(posedge clk);
         #1;
      end
      held = bus.fixed_o;
      chk("held_fixed", 64'(held), 64'hFFFD_8000);
      repeat (3) @(posedge clk);
      #1;
      chk("held_ready", 64'(bus.ready_o), 64'd1);
      chk("held_single", 64'(bus.fixed_o), 64'(held));
      @(negedge clk);
      bus.ack_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ack_i = 1'b0;
      bus.beg_i = 1'b0;
      chk("ack_wins", 64'({bus.busy_o, bus.ready_o}), 64'd0);
      @(posedge clk);
      #1;
      chk("idle_after_ack", 64'({bus.busy_o, bus.ready_o}), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
